axis_sample_capture: RTL and testbench
======================================

// Module: axis_sample_capture
// PURPOSE
//  Receiving end of the packed 128-bit ADC/filter AXI4-Stream (8 lanes x 16 b, 12-b sample in lane[15:4]).
//  Sinks one stream (e.g. buf or dac output of the L1 chain), unpacks to 8x12 b.
//  Records a pre/post-trigger window into a circular RAM; the window is readable after capture.
//  Sits on aclk beside the L1 trigger path; used for on-board verification of filter/trigger output.
// PARAMETERS
//  ADDR_BITS    10   RAM depth DEPTH = 2**ADDR_BITS words (one word = 8 samples)
//  PRETRIG      256  words kept before trigger word; 0 <= PRETRIG < DEPTH (elaboration error otherwise)
//  NSAMP        8    samples per beat (fixed, from package)
//  SAMPLE_BITS  12   bits per sample (fixed, from package)
// PORTS
//  aclk           in   1          stream/system clock; only clock
//  aresetn        in   1          asynchronous, active-low reset
//  s_axis_tdata   in   128        packed samples; lane i = [16i+15:16i], sample = [16i+15:16i+4], [16i+3:16i] ignored
//  s_axis_tvalid  in   1          beat valid
//  s_axis_tready  out  1          sink ready
//  arm_i          in   1          1-cycle pulse: start/restart capture
//  trig_i         in   1          trigger strobe, level-sampled each cycle
//  state_o        out  3          current FSM state encoding
//  done_o         out  1          window complete and frozen
//  trig_addr_o    out  ADDR_BITS  physical RAM address of trigger word
//  rd_en_i        in   1          read request
//  rd_addr_i      in   ADDR_BITS  logical index, 0 = oldest word of window
//  rd_data_o      out  96         unpacked word; sample i at [12i+11:12i]
//  rd_valid_o     out  1          rd_data_o valid
// BEHAVIOUR
//  Reset values: state IDLE, s_axis_tready=0, done_o=0, trig_addr_o=0, rd_valid_o=0, rd_data_o=0.
//   Counters are 0. RAM contents are not reset.
//  s_axis_tready=1 in every state once out of reset; the sink never back-pressures.
//   Beats arriving outside FILL/WAIT/POST are discarded.
//  Accept = tvalid & tready. wr_ptr advances mod DEPTH per accepted beat in FILL/WAIT/POST only.
//   Write data = unpacked 96 b; write takes effect in the same cycle.
//  FSM (IDLE, FILL, WAIT, POST, DONE):
//   any state + arm_i: wr_ptr=0, pre_cnt=0, done_o=0; go to FILL (go to WAIT if PRETRIG==0).
//    arm_i has priority over trig_i and over every other transition.
//   FILL: count accepted beats; the beat that makes pre_cnt==PRETRIG moves the FSM to WAIT.
//    trig_i is ignored in FILL.
//   WAIT: trig_i=1 -> trig_addr_o<=wr_ptr, post_cnt<=DEPTH-PRETRIG, go to POST.
//    A beat accepted in the trigger cycle is the trigger word and counts as post word 1.
//   POST: decrement post_cnt per accepted beat (trigger-cycle beat included).
//    The beat bringing post_cnt to 0 is the last one written; next state DONE.
//    trig_i is ignored in POST.
//   DONE: writes stop, done_o=1, held until the next arm_i or reset.
//  tvalid low: all counters and state hold. Gaps of any length are legal.
//  Window: oldest = (trig_addr_o - PRETRIG) mod DEPTH; total DEPTH words.
//  Read path: phys = (oldest + rd_addr_i) mod DEPTH, registered.
//   rd_data_o and rd_valid_o appear 2 cycles after rd_en_i. Fully pipelined: one read per cycle.
//   Reads are legal in any state; data is meaningful only while done_o=1.
//  Reset mid-capture: the FSM returns to IDLE asynchronously; done_o and tready drop immediately.
// STRUCTURE
//  pueo_capture_pkg:
//   capture_state_t enum (IDLE=0, FILL=1, WAIT=2, POST=3, DONE=4)
//   NSAMP, SAMPLE_BITS, LANE_BITS=16, LANE_LSB=4
//   function unpack128to96()
//  Sub-module capture_ram_sdp: simple dual-port, 1 write and 1 registered read port, DEPTH x 96, one clock.
//  Top holds the FSM, pointers, counters and read-address adder.
// TESTING (ADDR_BITS=4, PRETRIG=4 unless noted; beat n has sample i = (8n+i)&0xFFF)
//  1 Basic: arm before beat 0, trig_i with beat 20.
//    -> done_o rises after beat 31; trig_addr_o=4.
//    -> rd_addr 0 returns beat 16, rd_addr 4 returns beat 20, rd_addr 15 returns beat 31; rd_valid_o at +2 cycles.
//  2 Trigger in FILL ignored: trig at beat 2, then trig at beat 6.
//    -> window = beats 2..17; trig_addr_o=6.
//  3 tvalid toggling 1-0-0-1 for the whole run, trig with beat 10.
//    -> same content as a gap-free run (beats 6..21); no duplicate or skipped beats.
//  4 arm_i asserted with beat 25 of an active POST (and arm+trig in the same cycle).
//    -> restart: FILL; beat 25 is new word 0; no DONE until a fresh trigger.
//  5 aresetn low mid-POST.
//    -> state_o=IDLE, done_o=0, s_axis_tready=0 without a clock edge; after release, a new arm/trigger works normally.
//  6 Lane nibbles [3:0]=0xF and PRETRIG=0, trig with beat 0.
//    -> rd_data_o is unaffected by nibbles; window = beats 0..15.

Source files
------------

// File: rtl/pueo_capture_pkg.sv
// Shared types and helpers for the AXI4-Stream sample capture block.
// A beat is 8 lanes of 16 b; each lane carries a 12-b sample in its upper bits.
package pueo_capture_pkg;

  localparam int NSAMP       = 8;
  localparam int SAMPLE_BITS = 12;
  localparam int LANE_BITS   = 16;
  localparam int LANE_LSB    = 4;
  localparam int BEAT_BITS   = NSAMP * LANE_BITS;
  localparam int WORD_BITS   = NSAMP * SAMPLE_BITS;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } capture_state_t;

  // Drops the 4 low nibble bits of every lane and packs the samples densely.
  function automatic logic [WORD_BITS-1:0] unpack128to96(input logic [BEAT_BITS-1:0] beat);
    logic [WORD_BITS-1:0] word;
    word = '0;
    for (int i = 0; i < NSAMP; i++) begin
      word[i*SAMPLE_BITS +: SAMPLE_BITS] = beat[i*LANE_BITS+LANE_LSB +: SAMPLE_BITS];
    end
    return word;
  endfunction

endpackage

// File: rtl/capture_ram_sdp.sv
// Simple dual-port capture RAM: one write port, one registered read port, single clock.
// The storage array is never reset; only the read output register is.
module capture_ram_sdp #(
  parameter int ADDR_BITS = 10,
  parameter int WIDTH     = 96
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_sample_capture.sv
// Captures a pre/post-trigger window of unpacked sample words into a circular RAM
// and reads it back by logical index (0 = oldest word of the window).
module axis_sample_capture
  import pueo_capture_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int PRETRIG   = 256
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [BEAT_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 arm_i,
  input  logic                 trig_i,
  output logic [2:0]           state_o,
  output logic                 done_o,
  output logic [ADDR_BITS-1:0] trig_addr_o,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WORD_BITS-1:0] rd_data_o,
  output logic                 rd_valid_o
);

  localparam int DEPTH = 2**ADDR_BITS;

  if (PRETRIG < 0 || PRETRIG >= DEPTH) begin : g_bad_pretrig
    $error("axis_sample_capture: PRETRIG must satisfy 0 <= PRETRIG < 2**ADDR_BITS");
  end

  localparam logic [ADDR_BITS:0]   PRE_LEN  = (ADDR_BITS+1)'(PRETRIG);
  localparam logic [ADDR_BITS:0]   POST_LEN = (ADDR_BITS+1)'(DEPTH - PRETRIG);
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PRE_OFS  = ADDR_BITS'(PRETRIG);
  localparam bit PRE_ZERO = (PRETRIG == 0);
  localparam bit PRE_ONE  = (PRETRIG == 1);
  localparam bit POST_ONE = ((DEPTH - PRETRIG) == 1);

  capture_state_t       state, state_n;
  logic                 tready_q;
  logic [ADDR_BITS-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_BITS:0]   pre_cnt, pre_n;
  logic [ADDR_BITS:0]   post_cnt, post_n;
  logic [ADDR_BITS-1:0] trig_addr_n;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 accept;
  logic [ADDR_BITS-1:0] oldest;
  logic [ADDR_BITS-1:0] rd_phys;
  logic                 rd_en_q;

  // A beat transfers when tvalid & tready are both high on a rising aclk edge.
  // tready is high in every state once out of reset, so the sink never stalls.
  assign s_axis_tready = tready_q;
  assign accept        = s_axis_tvalid & tready_q;
  assign state_o       = state;
  assign done_o        = (state == DONE);

  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    pre_n       = pre_cnt;
    post_n      = post_cnt;
    trig_addr_n = trig_addr_o;
    wr_en       = 1'b0;
    wr_addr     = wr_ptr;
    if (arm_i) begin
      // A beat arriving with arm_i is already word 0 of the new capture.
      wr_en    = accept;
      wr_addr  = '0;
      wr_ptr_n = {{(ADDR_BITS-1){1'b0}}, accept};
      pre_n    = {{ADDR_BITS{1'b0}}, accept & !PRE_ZERO};
      post_n   = '0;
      state_n  = (PRE_ZERO || (accept && PRE_ONE)) ? WAIT : FILL;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            pre_n    = pre_cnt + 1'b1;
            if (pre_cnt + 1'b1 == PRE_LEN) begin
              state_n = WAIT;
            end
          end
        end
        WAIT: begin
          if (accept) begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
          end
          if (trig_i) begin
            trig_addr_n = wr_ptr;
            post_n      = accept ? POST_LEN - 1'b1 : POST_LEN;
            state_n     = (accept && POST_ONE) ? DONE : POST;
          end
        end
        POST: begin
          if (accept) begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            post_n   = post_cnt - 1'b1;
            if (post_cnt == CNT_ONE) begin
              state_n = DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      tready_q    <= 1'b0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      trig_addr_o <= '0;
    end else begin
      state       <= state_n;
      tready_q    <= 1'b1;
      wr_ptr      <= wr_ptr_n;
      pre_cnt     <= pre_n;
      post_cnt    <= post_n;
      trig_addr_o <= trig_addr_n;
    end
  end

  // Read side: logical index -> physical address (stage 1), RAM read (stage 2).
  assign oldest = trig_addr_o - PRE_OFS;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_phys    <= '0;
      rd_en_q    <= 1'b0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_phys    <= oldest + rd_addr_i;
      rd_en_q    <= rd_en_i;
      rd_valid_o <= rd_en_q;
    end
  end

  capture_ram_sdp #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (WORD_BITS)
  ) u_ram (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (unpack128to96(s_axis_tdata)),
    .rd_en   (rd_en_q),
    .rd_addr (rd_phys),
    .rd_data (rd_data_o)
  );

endmodule

// File: tb/tb_axis_sample_capture.sv
// Directed bench for axis_sample_capture: two instances (PRETRIG=4 and PRETRIG=0, 16-word RAM)
// share one stimulus stream; window read-backs are checked through an expected-word queue.
module tb_axis_sample_capture;

  localparam int AB = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [127:0]  tdata;
  logic          tvalid, arm, trig, rd_en;
  logic [AB-1:0] rd_addr;
  logic [3:0]    nib;

  logic          tready4, done4, rv4;
  logic [2:0]    state4;
  logic [AB-1:0] taddr4;
  logic [95:0]   rd4;
  logic          tready0, done0, rv0;
  logic [2:0]    state0;
  logic [AB-1:0] taddr0;
  logic [95:0]   rd0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [95:0] exp_q[$];

  // Clock and watchdog
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  axis_sample_capture #(.ADDR_BITS(AB), .PRETRIG(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready4), .arm_i(arm), .trig_i(trig), .state_o(state4), .done_o(done4),
    .trig_addr_o(taddr4), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd4),
    .rd_valid_o(rv4)
  );

  axis_sample_capture #(.ADDR_BITS(AB), .PRETRIG(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready0), .arm_i(arm), .trig_i(trig), .state_o(state0), .done_o(done0),
    .trig_addr_o(taddr0), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd0),
    .rd_valid_o(rv0)
  );

  function automatic logic [127:0] make_beat(input int n);
    logic [127:0] d;
    logic [11:0]  s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      s = 12'((8 * n + i) & 'hFFF);
      d[16*i +: 16] = {s, nib};
    end
    return d;
  endfunction

  function automatic logic [95:0] exp_word(input int n);
    logic [95:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[12*i +: 12] = 12'((8 * n + i) & 'hFFF);
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: one call = one clock cycle of stimulus
  task automatic cyc(input bit v, input int n, input bit t, input bit a);
    @(negedge aclk);
    tvalid = v;
    tdata  = v ? make_beat(n) : '0;
    trig   = t;
    arm    = a;
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    tdata  = '0;
    trig   = 1'b0;
    arm    = 1'b0;
  endtask

  task automatic beats(input int from, input int to);
    for (int n = from; n <= to; n++) cyc(1'b1, n, 1'b0, 1'b0);
  endtask

  // Reads the full window; expects beats first..first+15 with valid exactly 2 cycles after each request
  task automatic read_window(input bit sel0, input int first);
    logic        v;
    logic [95:0] d;
    for (int k = 0; k < 18; k++) begin
      @(negedge aclk);
      v = sel0 ? rv0 : rv4;
      d = sel0 ? rd0 : rd4;
      check("rd_valid", {127'd0, v}, {127'd0, (k >= 2)});
      if (v && exp_q.size() > 0) check("rd_data", {32'd0, d}, {32'd0, exp_q.pop_front()});
      if (k < 16) begin
        rd_en   = 1'b1;
        rd_addr = k[AB-1:0];
        exp_q.push_back(exp_word(first + k));
      end else begin
        rd_en = 1'b0;
      end
    end
    check("rd_queue_drained", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  initial begin
    aresetn = 1'b0;
    tdata   = '0;
    tvalid  = 1'b0;
    arm     = 1'b0;
    trig    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    nib     = 4'h0;

    // Reset values
    #12;
    check("rst_tready", {127'd0, tready4}, 128'd0);
    check("rst_state", {125'd0, state4}, {125'd0, S_IDLE});
    check("rst_done", {127'd0, done4}, 128'd0);
    check("rst_trig_addr", {124'd0, taddr4}, 128'd0);
    check("rst_rd_valid", {127'd0, rv4}, 128'd0);
    check("rst_rd_data", {32'd0, rd4}, 128'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("tready_up", {127'd0, tready4}, 128'd1);

    // 1 Basic capture
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("t1_fill", {125'd0, state4}, {125'd0, S_FILL});
    beats(0, 3);
    check("t1_wait", {125'd0, state4}, {125'd0, S_WAIT});
    beats(4, 19);
    cyc(1'b1, 20, 1'b1, 1'b0);
    check("t1_post", {125'd0, state4}, {125'd0, S_POST});
    check("t1_trig_addr", {124'd0, taddr4}, 128'd4);
    beats(21, 30);
    check("t1_not_done", {127'd0, done4}, 128'd0);
    cyc(1'b1, 31, 1'b0, 1'b0);
    check("t1_done", {127'd0, done4}, 128'd1);
    check("t1_state_done", {125'd0, state4}, {125'd0, S_DONE});
    read_window(1'b0, 16);
    beats(32, 35);
    check("t1_done_held", {127'd0, done4}, 128'd1);
    read_window(1'b0, 16);

    // 2 Trigger during FILL is ignored
    cyc(1'b0, 0, 1'b0, 1'b1);
    beats(0, 1);
    cyc(1'b1, 2, 1'b1, 1'b0);
    check("t2_fill_ignores_trig", {125'd0, state4}, {125'd0, S_FILL});
    beats(3, 5);
    cyc(1'b1, 6, 1'b1, 1'b0);
    check("t2_trig_addr", {124'd0, taddr4}, 128'd6);
    beats(7, 17);
    check("t2_done", {127'd0, done4}, 128'd1);
    read_window(1'b0, 2);

    // 3 tvalid pattern 1-0-0-1 throughout
    cyc(1'b0, 0, 1'b0, 1'b1);
    for (int n = 0; n <= 21; n++) begin
      cyc(1'b1, n, (n == 10), 1'b0);
      if (n == 20) check("t3_not_done", {127'd0, done4}, 128'd0);
      if (n < 21) begin
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
      end
    end
    check("t3_done", {127'd0, done4}, 128'd1);
    check("t3_trig_addr", {124'd0, taddr4}, 128'd10);
    read_window(1'b0, 6);

    // 4 arm+trig together in POST restarts; beat 25 becomes word 0
    cyc(1'b0, 0, 1'b0, 1'b1);
    beats(0, 19);
    cyc(1'b1, 20, 1'b1, 1'b0);
    beats(21, 24);
    check("t4_post", {125'd0, state4}, {125'd0, S_POST});
    cyc(1'b1, 25, 1'b1, 1'b1);
    check("t4_restart_fill", {125'd0, state4}, {125'd0, S_FILL});
    check("t4_restart_not_done", {127'd0, done4}, 128'd0);
    beats(26, 28);
    check("t4_wait", {125'd0, state4}, {125'd0, S_WAIT});
    beats(29, 40);
    check("t4_still_wait", {125'd0, state4}, {125'd0, S_WAIT});
    cyc(1'b1, 41, 1'b1, 1'b0);
    check("t4_trig_addr", {124'd0, taddr4}, 128'd0);
    beats(42, 51);
    check("t4_not_done", {127'd0, done4}, 128'd0);
    cyc(1'b1, 52, 1'b0, 1'b0);
    check("t4_done", {127'd0, done4}, 128'd1);
    read_window(1'b0, 37);

    // 5 Asynchronous reset during POST
    cyc(1'b0, 0, 1'b0, 1'b1);
    beats(0, 19);
    cyc(1'b1, 20, 1'b1, 1'b0);
    beats(21, 23);
    check("t5_post", {125'd0, state4}, {125'd0, S_POST});
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("t5_async_state", {125'd0, state4}, {125'd0, S_IDLE});
    check("t5_async_done", {127'd0, done4}, 128'd0);
    check("t5_async_tready", {127'd0, tready4}, 128'd0);
    check("t5_async_trig_addr", {124'd0, taddr4}, 128'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    cyc(1'b0, 0, 1'b0, 1'b0);
    check("t5_tready_back", {127'd0, tready4}, 128'd1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    beats(0, 4);
    cyc(1'b1, 5, 1'b1, 1'b0);
    check("t5_trig_addr", {124'd0, taddr4}, 128'd5);
    beats(6, 16);
    check("t5_done", {127'd0, done4}, 128'd1);
    read_window(1'b0, 1);

    // 6 PRETRIG=0 instance, lane nibbles all ones
    nib = 4'hF;
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("t6_wait_after_arm", {125'd0, state0}, {125'd0, S_WAIT});
    cyc(1'b1, 0, 1'b1, 1'b0);
    check("t6_trig_addr", {124'd0, taddr0}, 128'd0);
    check("t6_post", {125'd0, state0}, {125'd0, S_POST});
    beats(1, 14);
    check("t6_not_done", {127'd0, done0}, 128'd0);
    cyc(1'b1, 15, 1'b0, 1'b0);
    check("t6_done", {127'd0, done0}, 128'd1);
    read_window(1'b1, 0);
    nib = 4'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
